// File: rtl/viterbi_pkg.sv
// Shared convolutional-code constants and encoder FSM type for the Viterbi chain.
package viterbi_pkg;

    localparam int unsigned K      = 3;
    localparam int unsigned PAIR_W = 2;

    // Default generators, shared with the decoder's branch-metric chain
    localparam logic [K-1:0] VIT_G0 = 3'b111;
    localparam logic [K-1:0] VIT_G1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TAIL0 = 2'd2,
        TAIL1 = 2'd3
    } enc_state_t;

endpackage

// File: rtl/conv_parity.sv
// Combinational parity for one trellis step: {u, sr} against both generators.
// pair_c[1] comes from g0 and pair_c[0] from g1.
module conv_parity
    import viterbi_pkg::*;
(
    input  logic              u,
    input  logic [K-2:0]      sr,
    input  logic [K-1:0]      g0,
    input  logic [K-1:0]      g1,
    output logic [PAIR_W-1:0] pair_c
);

    logic [K-1:0] taps;

    // Current bit followed by the two previous bits, newest at the MSB
    assign taps   = {u, sr};
    assign pair_c = {^(g0 & taps), ^(g1 & taps)};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with a one-deep registered output slot.
// Build option: CONV_ENC_TAIL_EN appends two zero tail pairs per frame so the
// trellis terminates in state 00; without it sr is forced to 00 after in_last.
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0    = VIT_G0,
    parameter logic [K-1:0] G1    = VIT_G1,
    parameter int unsigned  CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              renew,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_bit,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PAIR_W-1:0] out_pair,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  pair_cnt
);

    enc_state_t          state_q;
    enc_state_t          state_d;
    logic [K-2:0]        sr_q;
    logic [K-2:0]        sr_d;
    logic                gen;
    logic                u;
    logic                last_d;
    logic                slot_free;
    logic                accept;
    logic                out_hs;
    logic                cnt_clr_q;
    logic [PAIR_W-1:0]   pair_c;

    // Output slot can take a new pair when empty or being drained this cycle
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = ((state_q == IDLE) || (state_q == DATA)) && !renew && slot_free;
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    conv_parity u_parity (
        .u      (u),
        .sr     (sr_q),
        .g0     (G0),
        .g1     (G1),
        .pair_c (pair_c)
    );

    // Next state, shift-register update and pair-generation strobe
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        gen     = 1'b0;
        u       = 1'b0;
        last_d  = 1'b0;
        case (state_q)
            IDLE, DATA: begin
                if (accept) begin
                    gen  = 1'b1;
                    u    = in_bit;
                    sr_d = {in_bit, sr_q[K-2]};
                    if (in_last) begin
`ifdef CONV_ENC_TAIL_EN
                        state_d = TAIL0;
`else
                        state_d = IDLE;
                        sr_d    = '0;
                        last_d  = 1'b1;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
`ifdef CONV_ENC_TAIL_EN
            TAIL0: begin
                if (slot_free) begin
                    gen     = 1'b1;
                    sr_d    = {1'b0, sr_q[K-2]};
                    state_d = TAIL1;
                end
            end
            TAIL1: begin
                if (slot_free) begin
                    gen     = 1'b1;
                    sr_d    = {1'b0, sr_q[K-2]};
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, output slot and per-frame pair counter; renew drops everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            out_valid <= 1'b0;
            out_pair  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            pair_cnt  <= '0;
            cnt_clr_q <= 1'b0;
        end else if (renew) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            pair_cnt  <= '0;
            cnt_clr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            busy    <= (state_d != IDLE);

            if (gen) begin
                out_valid <= 1'b1;
                out_pair  <= pair_c;
                out_last  <= last_d;
            end else if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            // Clear lands one cycle after the frame's final handshake
            if (cnt_clr_q) begin
                pair_cnt <= out_hs ? CNT_W'(1) : '0;
            end else if (out_hs && (pair_cnt != {CNT_W{1'b1}})) begin
                pair_cnt <= pair_cnt + CNT_W'(1);
            end
            cnt_clr_q <= out_hs && out_last;
        end
    end

endmodule
